// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache write-back buffer.
package dcache_pkg;

  localparam int DCACHE_PLEN          = 32;
  localparam int DCACHE_XLEN          = 32;
  localparam int DCACHE_BE_W          = DCACHE_XLEN / 8;
  localparam int DCACHE_WBUFFER_DEPTH = 4;

  localparam logic [2:0] MEMORY_REQUEST_SIZE_FOUR_BYTES = 3'b010;

  // One buffered word. A locked entry is owned by the drain logic and is
  // never merged into again.
  typedef struct packed {
    logic                   valid;
    logic                   locked;
    logic [DCACHE_PLEN-1:0] addr;
    logic [DCACHE_XLEN-1:0] data;
    logic [DCACHE_BE_W-1:0] be;
  } wbuffer_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_WAIT_ACK  = 2'd1,
    WB_WAIT_DONE = 2'd2
  } wbuffer_state_t;

  // Byte-wise merge: lanes with be set take new_data, others keep old_data.
  function automatic logic [DCACHE_XLEN-1:0] merge_bytes(
    input logic [DCACHE_XLEN-1:0] old_data,
    input logic [DCACHE_XLEN-1:0] new_data,
    input logic [DCACHE_BE_W-1:0] be
  );
    logic [DCACHE_XLEN-1:0] res;
    res = old_data;
    for (int i = 0; i < DCACHE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_wbuffer.sv
// Multi-entry write-back buffer between the dcache controller and memory.
// Absorbs word stores, coalesces into unlocked entries, forwards buffered
// bytes to loads and drains the oldest entry through a req/gnt/done handshake.
//
// Handshakes: a push is taken on a cycle where push_valid_i && push_ready_o;
// a memory request is taken when mem_req_o && mem_gnt_i; the drained entry is
// released on the cycle mem_done_i is seen while waiting for completion.
module dcache_wbuffer
  import dcache_pkg::*;
#(
  parameter int DEPTH      = DCACHE_WBUFFER_DEPTH,
  parameter int ADDR_WIDTH = DCACHE_PLEN,
  parameter int DATA_WIDTH = DCACHE_XLEN
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [ADDR_WIDTH-1:0]       push_addr_i,
  input  logic [DATA_WIDTH-1:0]       push_data_i,
  input  logic [DATA_WIDTH/8-1:0]     push_be_i,
  input  logic [ADDR_WIDTH-1:0]       lookup_addr_i,
  output logic                        lookup_hit_o,
  output logic [DATA_WIDTH/8-1:0]     lookup_be_o,
  output logic [DATA_WIDTH-1:0]       lookup_data_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_done_i,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_data_o,
  output logic [DATA_WIDTH/8-1:0]     mem_be_o,
  output logic [2:0]                  mem_size_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [1:0]                  dbg_state_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BE_W - 1);

  wbuffer_entry_t       entries_q [DEPTH];
  wbuffer_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  wbuffer_state_t       state_q, state_d;

  logic [ADDR_WIDTH-1:0] push_word;
  logic [ADDR_WIDTH-1:0] lookup_word;
  logic                  coal_hit;
  logic [PTR_W-1:0]      coal_idx;
  logic                  full;
  logic                  push_fire;
  logic                  alloc;
  logic                  lock_head;
  logic                  release_head;

  assign push_word   = push_addr_i & ~OFF_MASK;
  assign lookup_word = lookup_addr_i & ~OFF_MASK;

  // Find the unlocked entry (at most one) holding the pushed word.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && !entries_q[i].locked &&
          entries_q[i].addr == push_word) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // The slot freed by a same-cycle mem_done_i is deliberately not counted.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign push_ready_o = !full || coal_hit;
  assign push_fire    = push_valid_i && push_ready_o && (|push_be_i);

  // Drain FSM: lock the head, request it, then wait for completion.
  always_comb begin
    state_d      = state_q;
    lock_head    = 1'b0;
    release_head = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (entries_q[head_q].valid) begin
          lock_head = 1'b1;
          state_d   = WB_WAIT_ACK;
        end
      end
      WB_WAIT_ACK: begin
        if (mem_gnt_i) state_d = WB_WAIT_DONE;
      end
      WB_WAIT_DONE: begin
        if (mem_done_i) begin
          release_head = 1'b1;
          state_d      = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Entry storage and pointer updates; merge is applied before the lock so a
  // push that coalesces into the head on its locking cycle is not lost.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    alloc     = 1'b0;
    if (push_fire) begin
      if (coal_hit) begin
        entries_d[coal_idx].data = merge_bytes(entries_q[coal_idx].data,
                                               push_data_i, push_be_i);
        entries_d[coal_idx].be   = entries_q[coal_idx].be | push_be_i;
      end else begin
        entries_d[tail_q].valid  = 1'b1;
        entries_d[tail_q].locked = 1'b0;
        entries_d[tail_q].addr   = push_word;
        entries_d[tail_q].data   = push_data_i;
        entries_d[tail_q].be     = push_be_i;
        tail_d                   = tail_q + PTR_W'(1);
        alloc                    = 1'b1;
      end
    end
    if (lock_head) entries_d[head_q].locked = 1'b1;
    if (release_head) begin
      entries_d[head_q].valid  = 1'b0;
      entries_d[head_q].locked = 1'b0;
      head_d                   = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(release_head);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

  // Per byte lane, walk entries oldest to youngest so the youngest match wins.
  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic             lane_hit;
    logic [7:0]       lane_byte;
    logic [PTR_W-1:0] idx;
    always_comb begin
      lane_hit  = 1'b0;
      lane_byte = 8'h00;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if (entries_q[idx].valid && entries_q[idx].be[l] &&
            entries_q[idx].addr == lookup_word) begin
          lane_hit  = 1'b1;
          lane_byte = entries_q[idx].data[8*l +: 8];
        end
      end
    end
    assign lookup_be_o[l]            = lane_hit;
    assign lookup_data_o[8*l +: 8]   = lane_byte;
  end

  assign lookup_hit_o = |lookup_be_o;

  assign mem_req_o   = (state_q == WB_WAIT_ACK);
  assign mem_addr_o  = entries_q[head_q].addr;
  assign mem_data_o  = entries_q[head_q].data;
  assign mem_be_o    = entries_q[head_q].be;
  assign mem_size_o  = MEMORY_REQUEST_SIZE_FOUR_BYTES;
  assign empty_o     = (count_q == '0) && (state_q == WB_IDLE);
  assign count_o     = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_wbuffer.sv
// Bench for dcache_wbuffer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_dcache_wbuffer;
  import dcache_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 68;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        push_valid_i = 1'b0;
  logic        push_ready_o;
  logic [31:0] push_addr_i = '0;
  logic [31:0] push_data_i = '0;
  logic [3:0]  push_be_i = '0;
  logic [31:0] lookup_addr_i = '0;
  logic        lookup_hit_o;
  logic [3:0]  lookup_be_o;
  logic [31:0] lookup_data_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_done_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic [2:0]  mem_size_o;
  logic        empty_o;
  logic [2:0]  count_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // clock / reset
  always #5 clk_i = ~clk_i;

  dcache_wbuffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_be_i(push_be_i),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .lookup_be_o(lookup_be_o), .lookup_data_o(lookup_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_done_i(mem_done_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_size_o(mem_size_o), .empty_o(empty_o), .count_o(count_o),
    .dbg_state_o(dbg_state_o)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The buffer is an age-ordered queue of words; phase tracks the memory
  // conversation for the oldest word: 0 none, 1 requesting, 2 awaiting done.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          locked;
  } m_ent_t;

  m_ent_t mq[$];
  int     phase = 0;
  bit     started = 0;

  function automatic logic [31:0] wa(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic int find_open(input logic [31:0] a);
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].locked && mq[i].addr == wa(a)) return i;
    return -1;
  endfunction

  always @(posedge clk_i) begin : model
    int     old_size;
    int     hit;
    m_ent_t e;
    if (rst_i) begin
      mq.delete();
      phase   = 0;
      started = 1;
    end else if (started) begin
      old_size = mq.size();
      hit      = find_open(push_addr_i);
      if (push_valid_i && (old_size < DEPTH || hit >= 0) && push_be_i != 4'h0) begin
        if (hit >= 0) begin
          e = mq[hit];
          for (int l = 0; l < 4; l++)
            if (push_be_i[l]) e.data[8*l +: 8] = push_data_i[8*l +: 8];
          e.be    = e.be | push_be_i;
          mq[hit] = e;
        end else begin
          e.addr = wa(push_addr_i); e.data = push_data_i;
          e.be = push_be_i; e.locked = 0;
          mq.push_back(e);
        end
      end
      if (phase == 0) begin
        if (old_size > 0) begin
          e = mq[0]; e.locked = 1; mq[0] = e;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (mem_gnt_i) phase = 2;
      end else begin
        if (mem_done_i) begin
          void'(mq.pop_front());
          phase = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin : compare
    logic       exp_ready;
    logic [3:0] lbe;
    logic [31:0] ldata;
    if (started) begin
      exp_ready = (mq.size() < DEPTH) || (find_open(push_addr_i) >= 0);
      lbe = '0; ldata = '0;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].addr == wa(lookup_addr_i))
          for (int l = 0; l < 4; l++)
            if (mq[i].be[l]) begin
              lbe[l] = 1'b1;
              ldata[8*l +: 8] = mq[i].data[8*l +: 8];
            end
      chk("push_ready", W'(push_ready_o), W'(exp_ready));
      chk("count", W'(count_o), W'(mq.size()));
      chk("empty", W'(empty_o), W'(mq.size() == 0 && phase == 0));
      chk("mem_req", W'(mem_req_o), W'(phase == 1));
      chk("mem_size", W'(mem_size_o), W'(3'b010));
      chk("lookup_be", W'(lookup_be_o), W'(lbe));
      chk("lookup_data", W'(lookup_data_o), W'(ldata));
      chk("lookup_hit", W'(lookup_hit_o), W'(lbe != 4'h0));
      if (phase == 1 && mq.size() > 0)
        chk("mem_head", {mem_addr_o, mem_data_o, mem_be_o},
            {mq[0].addr, mq[0].data, mq[0].be});
      if (mem_req_o && mem_gnt_i)
        got_q.push_back({mem_addr_o, mem_data_o, mem_be_o});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    push_valid_i = v; push_addr_i = a; push_data_i = d; push_be_i = be;
  endtask

  task automatic drain();
    int n;
    n = 0;
    push_valid_i = 1'b0;
    mem_gnt_i = 1'b1; mem_done_i = 1'b1;
    #1;
    while (!empty_o && n < 300) begin
      tick();
      n++;
    end
    mem_gnt_i = 1'b0; mem_done_i = 1'b0;
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: buffer not empty after %0d cycles", n);
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwrites"}, W'(got_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_write"}, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int idx;
    int n;
    logic acc;

    // reset
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_ready", W'(push_ready_o), W'(1));
    chk("rst_empty", W'(empty_o), W'(1));
    chk("rst_count", W'(count_o), W'(0));
    chk("rst_req", W'(mem_req_o), W'(0));
    chk("rst_hit", W'(lookup_hit_o), W'(0));

    // coalesce two partial stores to one word
    set_push(1, 32'h1000, 32'h0000_00AA, 4'b0001); tick();
    set_push(1, 32'h1002, 32'h00BB_0000, 4'b0100); tick();
    push_valid_i = 0; #1;
    chk("coal_count", W'(count_o), W'(1));
    chk("coal_req", W'(mem_req_o), W'(1));
    chk("coal_head", {mem_addr_o, mem_data_o, mem_be_o}, {32'h1000, 32'h00BB_00AA, 4'b0101});
    exp_q.push_back({32'h1000, 32'h00BB_00AA, 4'b0101});
    drain();
    check_writes("coal");

    // full buffer back-pressure
    for (int i = 0; i < 4; i++) begin
      set_push(1, 32'h3000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF); tick();
      exp_q.push_back({32'h3000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF});
    end
    push_valid_i = 0;
    push_addr_i = 32'h3010; #1;
    chk("full_new", W'(push_ready_o), W'(0));
    push_addr_i = 32'h3004; #1;
    chk("full_coal", W'(push_ready_o), W'(1));
    push_addr_i = 32'h3000; #1;
    chk("full_locked", W'(push_ready_o), W'(0));
    push_addr_i = 32'h3010;
    mem_gnt_i = 1; tick();
    mem_gnt_i = 0; mem_done_i = 1; #1;
    chk("full_done_same", W'(push_ready_o), W'(0));
    tick();
    mem_done_i = 0; #1;
    chk("full_after_done", W'(push_ready_o), W'(1));
    drain();
    check_writes("full");

    // forwarding over a locked head
    set_push(1, 32'h2000, 32'h1122_3344, 4'hF); tick();
    push_valid_i = 0; mem_gnt_i = 1; tick(); tick();
    mem_gnt_i = 0;
    set_push(1, 32'h2000, 32'h0000_BEEF, 4'b0011); tick();
    push_valid_i = 0; lookup_addr_i = 32'h2000; #1;
    chk("fwd_data", W'(lookup_data_o), W'(32'h1122_BEEF));
    chk("fwd_be", W'(lookup_be_o), W'(4'hF));
    chk("fwd_hit", W'(lookup_hit_o), W'(1));
    chk("fwd_count", W'(count_o), W'(2));
    exp_q.push_back({32'h2000, 32'h1122_3344, 4'hF});
    exp_q.push_back({32'h2000, 32'h0000_BEEF, 4'b0011});
    drain();
    check_writes("fwd");

    // wrap-around over ten sequential words
    idx = 0; n = 0;
    mem_gnt_i = 1; mem_done_i = 1;
    while (!(idx == 10 && empty_o) && n < 200) begin
      if (idx < 10) set_push(1, 32'h100 + 32'(4*idx), 32'(idx) * 32'h0101_0101, 4'hF);
      else push_valid_i = 0;
      #1;
      acc = push_valid_i && push_ready_o;
      tick();
      if (acc) idx++;
      n++;
    end
    push_valid_i = 0; mem_gnt_i = 0; mem_done_i = 0;
    for (int i = 0; i < 10; i++)
      exp_q.push_back({32'h100 + 32'(4*i), 32'(i) * 32'h0101_0101, 4'hF});
    #1;
    chk("wrap_empty", W'(empty_o), W'(1));
    check_writes("wrap");

    // simultaneous push and done at count 2
    set_push(1, 32'h400, 32'h4, 4'hF); tick();
    set_push(1, 32'h404, 32'h5, 4'hF); tick();
    push_valid_i = 0; mem_gnt_i = 1; tick();
    mem_gnt_i = 0; #1;
    chk("simul_before", W'(count_o), W'(2));
    set_push(1, 32'h408, 32'h6, 4'hF); mem_done_i = 1; tick();
    push_valid_i = 0; mem_done_i = 0; #1;
    chk("simul_after", W'(count_o), W'(2));
    exp_q.push_back({32'h400, 32'h4, 4'hF});
    exp_q.push_back({32'h404, 32'h5, 4'hF});
    exp_q.push_back({32'h408, 32'h6, 4'hF});
    drain();
    check_writes("simul");

    // reset while requesting
    for (int i = 0; i < 3; i++) begin
      set_push(1, 32'h500 + 32'(4*i), 32'h77, 4'hF); tick();
    end
    push_valid_i = 0; lookup_addr_i = 32'h500; #1;
    chk("mrst_req_before", W'(mem_req_o), W'(1));
    chk("mrst_count_before", W'(count_o), W'(3));
    rst_i = 1; tick();
    rst_i = 0; #1;
    chk("mrst_req", W'(mem_req_o), W'(0));
    chk("mrst_count", W'(count_o), W'(0));
    chk("mrst_empty", W'(empty_o), W'(1));
    chk("mrst_hit", W'(lookup_hit_o), W'(0));
    check_writes("mrst");

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      push_valid_i  = 1'($urandom_range(0, 1));
      push_addr_i   = 32'h600 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      push_data_i   = $urandom;
      push_be_i     = 4'($urandom_range(0, 15));
      lookup_addr_i = 32'h600 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      mem_gnt_i     = 1'($urandom_range(0, 1));
      mem_done_i    = ($urandom_range(0, 2) == 0);
      rst_i         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst_i = 0;
    drain();
    got_q.delete();

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end

endmodule
